// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings, NOP word,
// and PC alignment helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_t;

  // sll r0,r0,0
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch_stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_stage_hold_buf.sv
// Single-entry buffer that parks a fetched word and its PC while the
// pipeline is paused; clear takes priority over load.
module fetch_hold_buf (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_word,
  input  logic [31:0] load_pc,
  output logic [31:0] word,
  output logic [31:0] word_pc,
  output logic        valid
);

  logic [31:0] word_reg;
  logic [31:0] word_pc_reg;
  logic        valid_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      word_reg    <= '0;
      word_pc_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (clear) begin
      valid_reg   <= 1'b0;
    end else if (load) begin
      word_reg    <= load_word;
      word_pc_reg <= load_pc;
      valid_reg   <= 1'b1;
    end
  end

  assign word    = word_reg;
  assign word_pc = word_pc_reg;
  assign valid   = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem handshake and
// loads the IF/ID register, absorbing wait states, pause and redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = NOP_WORD
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [31:0]   pc_next,
  input  logic          pause,
  input  logic          flush,
  output logic [31:0]   pc,
  output logic [31:0]   ins_o,
  output logic [31:0]   ins_pc,
  output logic          ins_valid,
  output logic          fetch_stall,
  fetch_stage_if.master imem
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  redir_pc_reg, redir_pc_next;
  logic         redir_pend_reg, redir_pend_next;
  logic [31:0]  ins_reg, ins_next;
  logic [31:0]  ins_pc_reg, ins_pc_next;
  logic         ins_valid_reg, ins_valid_next;
  logic         req_reg;
  logic         hold_load, hold_clear;
  logic [31:0]  hold_word, hold_pc;
  logic         hold_valid;
  logic [31:0]  target;

  fetch_hold_buf u_hold (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_word (imem.rdata),
    .load_pc   (fetch_pc_reg),
    .word      (hold_word),
    .word_pc   (hold_pc),
    .valid     (hold_valid)
  );

  assign target = align_pc(pc_next);

  always_comb begin
    state_next      = state_reg;
    fetch_pc_next   = fetch_pc_reg;
    redir_pc_next   = redir_pc_reg;
    redir_pend_next = redir_pend_reg;
    ins_next        = ins_reg;
    ins_pc_next     = ins_pc_reg;
    ins_valid_next  = ins_valid_reg;
    hold_load       = 1'b0;
    hold_clear      = 1'b0;
    case (state_reg)
      FS_IDLE: state_next = FS_REQ;
      FS_REQ: begin
        if (flush) begin
          ins_next       = NOP_INS;
          ins_valid_next = 1'b0;
          hold_clear     = 1'b1;
          if (imem.ack) begin
            fetch_pc_next   = target;
            redir_pend_next = 1'b0;
          end else begin
            // Request still in flight: remember the target until its ack.
            redir_pc_next   = target;
            redir_pend_next = 1'b1;
          end
        end else if (imem.ack) begin
          if (redir_pend_reg) begin
            fetch_pc_next   = redir_pc_reg;
            redir_pend_next = 1'b0;
          end else if (!pause) begin
            ins_next       = imem.rdata;
            ins_pc_next    = fetch_pc_reg;
            ins_valid_next = 1'b1;
            fetch_pc_next  = target;
          end else begin
            hold_load  = 1'b1;
            state_next = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (flush) begin
          ins_next       = NOP_INS;
          ins_valid_next = 1'b0;
          hold_clear     = 1'b1;
          fetch_pc_next  = target;
          state_next     = FS_REQ;
        end else if (!pause) begin
          ins_next       = hold_word;
          ins_pc_next    = hold_pc;
          ins_valid_next = hold_valid;
          hold_clear     = 1'b1;
          fetch_pc_next  = target;
          state_next     = FS_REQ;
        end
      end
      default: state_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FS_IDLE;
      fetch_pc_reg   <= RESET_PC;
      redir_pc_reg   <= RESET_PC;
      redir_pend_reg <= 1'b0;
      ins_reg        <= NOP_INS;
      ins_pc_reg     <= RESET_PC;
      ins_valid_reg  <= 1'b0;
      req_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      fetch_pc_reg   <= fetch_pc_next;
      redir_pc_reg   <= redir_pc_next;
      redir_pend_reg <= redir_pend_next;
      ins_reg        <= ins_next;
      ins_pc_reg     <= ins_pc_next;
      ins_valid_reg  <= ins_valid_next;
      req_reg        <= (state_next == FS_REQ);
    end
  end

  assign fetch_stall = (state_reg == FS_IDLE)
                     | ((state_reg == FS_REQ) & ~imem.ack)
                     | ((state_reg == FS_REQ) & redir_pend_reg);

  assign pc        = fetch_pc_reg;
  assign imem.req  = req_reg;
  assign imem.addr = fetch_pc_reg;
  assign ins_o     = ins_reg;
  assign ins_pc    = ins_pc_reg;
  assign ins_valid = ins_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch model;
// memory returns addr ^ 32'hA5A5_0000 with random wait states.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] XORK     = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_next = '0;
  logic        pause = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc, ins_o, ins_pc;
  logic        ins_valid, fetch_stall;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INS(NOP)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .pc_next     (pc_next),
    .pause       (pause),
    .flush       (flush),
    .pc          (pc),
    .ins_o       (ins_o),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .fetch_stall (fetch_stall),
    .imem        (imem_bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase of the fetch unit, the architectural PC, the
  // word parked during pause, and any redirect waiting on a stale ack.
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_PARKED = 2;
  typedef struct { logic [31:0] word; logic [31:0] addr; } fetched_t;

  int          m_phase;
  logic [31:0] m_pc;
  fetched_t    m_parked[$];
  logic        m_redirect;
  logic [31:0] m_redirect_pc;
  logic [31:0] m_ins, m_ins_pc;
  logic        m_valid;

  task automatic model_reset();
    m_phase    = PH_IDLE;
    m_pc       = RESET_PC;
    m_parked.delete();
    m_redirect = 1'b0;
    m_redirect_pc = RESET_PC;
    m_ins      = NOP;
    m_ins_pc   = RESET_PC;
    m_valid    = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("pc",        pc,                 m_pc);
    check_eq("imem_req",  {31'd0, imem_bus.req}, {31'd0, m_phase == PH_FETCH});
    check_eq("imem_addr", imem_bus.addr,      m_pc);
    check_eq("ins_o",     ins_o,              m_ins);
    check_eq("ins_valid", {31'd0, ins_valid}, {31'd0, m_valid});
    if (m_valid) check_eq("ins_pc", ins_pc, m_ins_pc);
  endtask

  task automatic deliver(input logic [31:0] word, input logic [31:0] addr);
    m_ins    = word;
    m_ins_pc = addr;
    m_valid  = 1'b1;
    $display("ins pc=%h word=%h t=%0t", addr, word, $time);
  endtask

  // Drive one cycle of inputs at a falling edge, advance the model across the
  // next rising edge, then compare on the following falling edge.
  task automatic step(input int pause_pct, input int flush_pct, input int ack_pct);
    logic ack;
    logic [31:0] tgt;
    pause = ($urandom_range(99) < pause_pct);
    flush = (m_phase != PH_IDLE) && ($urandom_range(99) < flush_pct);
    if (flush || $urandom_range(9) == 0) pc_next = $urandom;
    else pc_next = m_pc + 32'd4;
    ack = (m_phase != PH_PARKED) && ($urandom_range(99) < ack_pct);
    imem_bus.ack   = ack;
    imem_bus.rdata = (m_phase == PH_FETCH) ? (m_pc ^ XORK) : $urandom;
    #1;
    check_eq("fetch_stall", {31'd0, fetch_stall},
             {31'd0, (m_phase == PH_IDLE) || (m_phase == PH_FETCH && (!ack || m_redirect))});
    tgt = {pc_next[31:2], 2'b00};
    if (m_phase == PH_IDLE) begin
      m_phase = PH_FETCH;
    end else if (flush) begin
      m_ins   = NOP;
      m_valid = 1'b0;
      m_parked.delete();
      if (m_phase == PH_PARKED || ack) begin
        m_pc       = tgt;
        m_redirect = 1'b0;
      end else begin
        m_redirect    = 1'b1;
        m_redirect_pc = tgt;
      end
      m_phase = PH_FETCH;
    end else if (m_phase == PH_FETCH && ack) begin
      if (m_redirect) begin
        m_pc       = m_redirect_pc;
        m_redirect = 1'b0;
      end else if (!pause) begin
        deliver(m_pc ^ XORK, m_pc);
        m_pc = tgt;
      end else begin
        m_parked.push_back('{word: m_pc ^ XORK, addr: m_pc});
        m_phase = PH_PARKED;
      end
    end else if (m_phase == PH_PARKED && !pause) begin
      if (m_parked.size() != 0) begin
        fetched_t f;
        f = m_parked.pop_front();
        deliver(f.word, f.addr);
      end
      m_pc    = tgt;
      m_phase = PH_FETCH;
    end
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check_outputs();
    check_eq("reset_ins_pc", ins_pc, RESET_PC);
    rst_n = 1'b1;
    check_outputs();

    // Zero-wait memory: one instruction per cycle from RESET_PC upward.
    for (int i = 0; i < 12; i++) step(0, 0, 100);
    for (int i = 0; i < 300; i++) step(25, 8, 50);

    // Asynchronous reset in the middle of a cycle, with a stray ack present.
    @(posedge clock);
    #2;
    imem_bus.ack = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("reset_ins_pc_async", ins_pc, RESET_PC);
    check_eq("reset_stall", {31'd0, fetch_stall}, 32'd1);
    @(negedge clock);
    rst_n = 1'b1;
    check_outputs();

    for (int i = 0; i < 8; i++) step(0, 0, 100);
    for (int i = 0; i < 200; i++) step(30, 10, 40);
    for (int i = 0; i < 100; i++) step(60, 5, 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly downstream of `pc_gen`. It holds the architectural fetch PC register. Each cycle it registers `pc_gen`'s `pc_next` and feeds the registered PC back to `pc_gen`. It runs a request/acknowledge handshake with instruction memory and delivers each fetched word, with its PC, into the IF/ID register consumed by decode (`ext`, `compare`, `reg_array` addressing). It absorbs memory wait states, pipeline pause and branch/jump/IRQ flush without losing or duplicating instructions.

## Interface
Clock and reset (already decided): one clock, `clock`; reset `rst_n`, asynchronous, active-low.

Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `NOP_INS`, default 32'h0000_0000: word presented on `ins_o` when no valid instruction is present (sll r0,r0,0).

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pc_next`  in  32  next PC from `pc_gen`; sampled on advance and on flush.
- `pause`  in  1  global pipeline pause (hazard/data-memory), excluding `fetch_stall`.
- `flush`  in  1  one-cycle redirect pulse; `pc_next` holds the redirect target in that cycle.
- `pc`  out  32  current fetch PC; drives `pc_gen.pc`.
- `imem_req`  out  1  instruction-memory request, registered.
- `imem_addr`  out  32  request address; equals `pc`.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched word.
- `ins_o`  out  32  IF/ID instruction to decode.
- `ins_pc`  out  32  PC of `ins_o`.
- `ins_valid`  out  1  `ins_o` is a real instruction.
- `fetch_stall`  out  1  combinational; top ORs it into the pause sent to the rest of the pipeline.

## Operation
- FSM states:
  - FS_IDLE: only after reset.
  - FS_REQ: request outstanding.
  - FS_HOLD: word captured while paused.
- FS_IDLE: `imem_req`=0. The next edge enters FS_REQ with `imem_req`=1.
- FS_REQ: `imem_req`=1. `imem_addr`=`pc`, stable until ack.
  - ack, `pause`=0, no flush: `ins_o`<=`imem_rdata`, `ins_pc`<=`pc`, `ins_valid`<=1, `pc`<=`pc_next`. Stay in FS_REQ (back-to-back request to the new address).
  - ack, `pause`=1, no flush: word+PC go into the hold buffer. IF/ID is unchanged. Go to FS_HOLD, `imem_req`<=0.
  - no ack: everything holds.
- FS_HOLD: `imem_req`=0. When `pause` falls, IF/ID<=hold buffer, `pc`<=`pc_next`, go to FS_REQ.
- Flush rules:
  - Flush has priority over pause and ack.
  - IF/ID<=`NOP_INS`, `ins_valid`<=0.
  - The hold buffer is invalidated.
  - With ack in FS_REQ, or in FS_HOLD: `pc`<=`pc_next` and the state becomes FS_REQ; a returned word is discarded.
  - Flush in FS_REQ without ack: the target goes into `redir_pc` and `redir_pend` is set. The in-flight request completes at the old address and its data is discarded, then `pc`<=`redir_pc` and `redir_pend` clears.
  - A second flush while `redir_pend` is set overwrites `redir_pc`.
- `fetch_stall` = (FS_IDLE) | (FS_REQ & ~imem_ack) | (FS_REQ & redir_pend).
- While `pause`=1 and no flush, IF/ID holds its value.
- Widths: all PCs are 32 bits. `pc[1:0]` is forced to 0 and `pc_next[1:0]` is ignored. No overflow handling: the PC wraps modulo 2^32.

## Timing
- Reset values, asynchronous:
  - state FS_IDLE
  - `pc`=`ins_pc`=`RESET_PC`
  - `ins_o`=`NOP_INS`
  - `ins_valid`=0
  - `imem_req`=0
  - `redir_pend`=0, hold buffer invalid
- First request is at edge 1 after `rst_n` rises.
- Latency: `ins_o` updates on the edge of the ack cycle. With a zero-wait memory (ack in the request cycle), throughput is one instruction per cycle.
- Reset asserted mid-request: all state clears immediately. The memory must drop any pending ack; a late ack in FS_IDLE is ignored.
- `flush` and `pause` are sampled only at edges. Redirect to the new target is visible on `pc` the edge after the flush, or the edge after the stale ack.

## Structure
- Add to `mips789_defs.v`:
  - state encodings `FS_IDLE`, `FS_REQ`, `FS_HOLD` (2-bit)
  - `NOP_WORD` constant, used as the `NOP_INS` default
- One sub-module, `fetch_hold_buf`: a single-entry buffer holding data, PC and valid, with load/clear/read.
- FSM, redirect logic and IF/ID register live in `fetch_stage`.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_0000 → requests at 0x0, 0x4, 0x8. `ins_o` at edges 2/3/4 is 0xA5A5_0000/…04/…08, `ins_valid`=1.
- 3-wait-state ack at PC 0x10 → `fetch_stall`=1 for 3 cycles. `imem_addr` stays 0x10. `ins_pc`=0x10 on the ack edge.
- `pause` high for 4 cycles, ack arrives in pause cycle 1 → FS_HOLD, `imem_req`=0, IF/ID unchanged. On pause release, `ins_o`=the word from PC 0x20, `pc`=0x24, no duplicate fetch.
- `flush` with `pc_next`=0x100 during an outstanding request to 0x40, ack 2 cycles later → word from 0x40 is discarded, `ins_valid`=0. Next request is to 0x100.
- Simultaneous `flush`+ack+`pause` in FS_REQ → `ins_o`=`NOP_INS`, `ins_valid`=0, `pc`=flush target, state FS_REQ.
- `rst_n` low mid-wait → outputs return to reset values asynchronously. A stray ack is ignored and the first post-reset request goes to `RESET_PC`.
